// File: rtl/fir_arith_pkg.sv
// Shared arithmetic helpers for the cascade FIR datapath: prefix-tree cells,
// ceil-log2 and the mid-tree pipeline split point.
package fir_arith_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Prefix level after which the optional mid-tree register sits.
  function automatic int mid_split(input int w);
    return (clog2(w) + 1) / 2;
  endfunction

  localparam int LF_MID_W16 = mid_split(16);

  // Cells return {g, p} (black) or g alone (grey) for the span [hi:lo].
  function automatic logic [1:0] black_cell(input logic gh, input logic ph,
                                            input logic gl, input logic pl);
    return {gh | (ph & gl), ph & pl};
  endfunction

  function automatic logic grey_cell(input logic gh, input logic ph, input logic gl);
    return gh | (ph & gl);
  endfunction

  // Reduced cells: the low side is a bare generate (carry-in as bit -1).
  function automatic logic [1:0] rblack_cell(input logic gh, input logic ph, input logic cin);
    return {gh | (ph & cin), 1'b0};
  endfunction

  function automatic logic rgrey_cell(input logic gh, input logic ph, input logic cin);
    return gh | (ph & cin);
  endfunction

endpackage

// File: rtl/lf_pipe_adder_if.sv
// Valid/ready operand and result streams of the pipelined prefix adder.
interface lf_pipe_adder_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/lf_prefix_tree.sv
// Slice of a Ladner-Fischer prefix tree covering levels LO_LVL..HI_LVL.
// Levels 0..clog2(WIDTH)-1 work on odd bits; level clog2(WIDTH) fills even bits.
module lf_prefix_tree
  import fir_arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LO_LVL = 0,
  parameter int HI_LVL = clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] g_in,
  input  logic [WIDTH-1:0] p_in,
  output logic [WIDTH-1:0] g_out,
  output logic [WIDTH-1:0] p_out
);
  localparam int NL = clog2(WIDTH);

  // Partner bit for node i at level l, or -1 when the node passes through.
  function automatic int lf_partner(input int i, input int l, input int nl);
    if (l == nl) return ((i % 2 == 0) && (i > 0)) ? i - 1 : -1;
    if (i % 2 == 0) return -1;
    if (l == 0) return i - 1;
    if (((i >> l) & 1) == 1) return ((i >> l) << l) - 1;
    return -1;
  endfunction

  // Lowest bit covered by node j once level l has been applied.
  function automatic int lf_low(input int j, input int l, input int nl);
    if (l < 0) return j;
    if (l >= nl) return 0;
    if (j % 2 == 0) return j;
    return (j >> (l + 1)) << (l + 1);
  endfunction

  for (genvar l = LO_LVL; l <= HI_LVL; l++) begin : g_lvl
    logic [WIDTH-1:0] g_cur, p_cur, g_nxt, p_nxt;
    if (l == LO_LVL) begin : g_first
      assign g_cur = g_in;
      assign p_cur = p_in;
    end else begin : g_chain
      assign g_cur = g_lvl[l-1].g_nxt;
      assign p_cur = g_lvl[l-1].p_nxt;
    end
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int J    = lf_partner(i, l, NL);
      localparam bit GREY = (J >= 0) && (lf_low(J, l - 1, NL) == 0);
      if (J < 0) begin : g_pass
        assign g_nxt[i] = g_cur[i];
        assign p_nxt[i] = p_cur[i];
      end else if (GREY) begin : g_grey
        assign g_nxt[i] = grey_cell(g_cur[i], p_cur[i], g_cur[J]);
        assign p_nxt[i] = p_cur[i];
      end else begin : g_black
        assign {g_nxt[i], p_nxt[i]} = black_cell(g_cur[i], p_cur[i], g_cur[J], p_cur[J]);
      end
    end
  end

  assign g_out = g_lvl[HI_LVL].g_nxt;
  assign p_out = g_lvl[HI_LVL].p_nxt;
endmodule

// File: rtl/lf_pipe_adder.sv
// Pipelined Ladner-Fischer adder/subtractor with carry-in, signed overflow,
// optional saturation and a stall-everything valid/ready pipeline.
module lf_pipe_adder
  import fir_arith_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int MID_REG = 1,
  parameter int SAT     = 0
) (
  input logic            clk,
  input logic            rst,
  lf_pipe_adder_if.slave bus
);
  localparam int NL  = clog2(WIDTH);
  localparam int MID = mid_split(WIDTH);

  function automatic logic signed [WIDTH-1:0] sat_fn(input logic signed [WIDTH-1:0] raw,
                                                     input logic ovf, input logic a_msb);
    if ((SAT != 0) && ovf)
      return a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return raw;
  endfunction

  logic                    stall;
  logic                    vld_p0, vld_m, vld_p2;
  logic [WIDTH-1:0]        a_p0, b_p0, h_p0, g_pre, p_pre;
  logic                    cin_p0;
  logic [1:0]              cell0;
  logic [WIDTH-1:0]        g_c, p_unused, h_m, c_vec;
  logic                    cin_m, amsb_m, bmsb_m;
  logic signed [WIDTH-1:0] raw_sum, sum_p2;
  logic                    cout_c, ovf_c, cout_p2, ovf_p2;

  assign stall         = vld_p2 && !bus.out_ready;
  assign bus.in_ready  = !stall;
  assign bus.out_valid = vld_p2;
  assign bus.out_sum   = sum_p2;
  assign bus.out_cout  = cout_p2;
  assign bus.out_ovf   = ovf_p2;

  // Stage 1: conditioned operands (subtract = add inverted B and inverted borrow)
  always_ff @(posedge clk or posedge rst)
    if (rst) vld_p0 <= 1'b0;
    else if (!stall) vld_p0 <= bus.in_valid;

  always_ff @(posedge clk)
    if (bus.in_valid && !stall) begin
      a_p0   <= bus.in_a;
      b_p0   <= bus.in_sub ? ~bus.in_b : bus.in_b;
      cin_p0 <= bus.in_sub ? ~bus.in_cin : bus.in_cin;
    end

  always_comb begin
    cell0    = rblack_cell(a_p0[0] & b_p0[0], a_p0[0] | b_p0[0], cin_p0);
    g_pre    = a_p0 & b_p0;
    g_pre[0] = cell0[1];
    p_pre    = a_p0 | b_p0;
    p_pre[0] = cell0[0];
  end

  assign h_p0 = a_p0 ^ b_p0;

  if (MID_REG != 0) begin : g_mid
    logic [WIDTH-1:0] g_lo, p_lo, g_p1, p_p1, h_p1;
    logic             cin_p1, amsb_p1, bmsb_p1, vld_p1;

    lf_prefix_tree #(.WIDTH(WIDTH), .LO_LVL(0), .HI_LVL(MID - 1)) u_lo (
      .g_in(g_pre), .p_in(p_pre), .g_out(g_lo), .p_out(p_lo)
    );

    // Stage mid: partial prefix state plus what the sum/overflow logic needs
    always_ff @(posedge clk or posedge rst)
      if (rst) vld_p1 <= 1'b0;
      else if (!stall) vld_p1 <= vld_p0;

    always_ff @(posedge clk)
      if (vld_p0 && !stall) begin
        g_p1    <= g_lo;
        p_p1    <= p_lo;
        h_p1    <= h_p0;
        cin_p1  <= cin_p0;
        amsb_p1 <= a_p0[WIDTH-1];
        bmsb_p1 <= b_p0[WIDTH-1];
      end

    lf_prefix_tree #(.WIDTH(WIDTH), .LO_LVL(MID), .HI_LVL(NL)) u_hi (
      .g_in(g_p1), .p_in(p_p1), .g_out(g_c), .p_out(p_unused)
    );

    assign h_m    = h_p1;
    assign cin_m  = cin_p1;
    assign amsb_m = amsb_p1;
    assign bmsb_m = bmsb_p1;
    assign vld_m  = vld_p1;
  end else begin : g_nomid
    lf_prefix_tree #(.WIDTH(WIDTH), .LO_LVL(0), .HI_LVL(NL)) u_all (
      .g_in(g_pre), .p_in(p_pre), .g_out(g_c), .p_out(p_unused)
    );

    assign h_m    = h_p0;
    assign cin_m  = cin_p0;
    assign amsb_m = a_p0[WIDTH-1];
    assign bmsb_m = b_p0[WIDTH-1];
    assign vld_m  = vld_p0;
  end

  always_comb begin
    c_vec   = {g_c[WIDTH-2:0], cin_m};
    raw_sum = h_m ^ c_vec;
    cout_c  = g_c[WIDTH-1];
    ovf_c   = (amsb_m == bmsb_m) && (raw_sum[WIDTH-1] != amsb_m);
  end

  // Stage out: result registers only load when a valid beat advances
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vld_p2  <= 1'b0;
      sum_p2  <= '0;
      cout_p2 <= 1'b0;
      ovf_p2  <= 1'b0;
    end else if (!stall) begin
      vld_p2 <= vld_m;
      if (vld_m) begin
        sum_p2  <= sat_fn(raw_sum, ovf_c, amsb_m);
        cout_p2 <= cout_c;
        ovf_p2  <= ovf_c;
      end
    end
endmodule

// File: tb/tb_lf_pipe_adder.sv
// Bench for lf_pipe_adder: directed cases on two 16-bit instances (wrap and
// saturate) plus a randomized scoreboard run over sixteen configurations.
module tb_lf_pipe_adder;
  localparam int NB = 10000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_d, rst_r, rand_go;
  logic        vld_d, cin_d, sub_d, ordy_d;
  logic [15:0] a_d, b_d, snap_s, snap_a;
  int          total = 0;
  int          bad = 0;
  int          ndone = 0;
  logic [65:0] q_a[$];
  logic [65:0] q_b[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference: plain wide addition, returns {ovf, cout, sum}.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub,
                                        input int w, input bit sat);
    logic [64:0] mask, full;
    logic [63:0] be, s;
    logic        ce, ov, am, bm;
    mask = (65'd1 << w) - 65'd1;
    be   = (sub ? ~b : b) & mask[63:0];
    ce   = sub ? ~cin : cin;
    full = {1'b0, a & mask[63:0]} + {1'b0, be} + {64'd0, ce};
    s    = full[63:0] & mask[63:0];
    am   = a[w-1];
    bm   = be[w-1];
    ov   = (am == bm) && (s[w-1] != am);
    if (sat && ov) s = am ? (64'd1 << (w - 1)) : ((64'd1 << (w - 1)) - 64'd1);
    return {ov, full[w], s};
  endfunction

  lf_pipe_adder_if #(.WIDTH(16)) ba();
  lf_pipe_adder_if #(.WIDTH(16)) bb();

  assign ba.in_valid  = vld_d;
  assign ba.in_a      = a_d;
  assign ba.in_b      = b_d;
  assign ba.in_cin    = cin_d;
  assign ba.in_sub    = sub_d;
  assign ba.out_ready = ordy_d;
  assign bb.in_valid  = vld_d;
  assign bb.in_a      = a_d;
  assign bb.in_b      = b_d;
  assign bb.in_cin    = cin_d;
  assign bb.in_sub    = sub_d;
  assign bb.out_ready = ordy_d;

  lf_pipe_adder #(.WIDTH(16), .MID_REG(1), .SAT(0)) u_a (.clk(clk), .rst(rst_d), .bus(ba));
  lf_pipe_adder #(.WIDTH(16), .MID_REG(1), .SAT(1)) u_b (.clk(clk), .rst(rst_d), .bus(bb));

  always @(negedge clk) begin
    logic [65:0] e;
    if (!rst_d && ba.out_valid && ba.out_ready) begin
      if (q_a.size() == 0) chk("a_extra_beat", 64'(ba.out_sum), 64'hDEAD);
      else begin
        e = q_a.pop_front();
        chk("a_sum", 64'(ba.out_sum), e[63:0]);
        chk("a_cout", 64'(ba.out_cout), 64'(e[64]));
        chk("a_ovf", 64'(ba.out_ovf), 64'(e[65]));
      end
    end
    if (!rst_d && bb.out_valid && bb.out_ready) begin
      if (q_b.size() == 0) chk("b_extra_beat", 64'(bb.out_sum), 64'hDEAD);
      else begin
        e = q_b.pop_front();
        chk("b_sum", 64'(bb.out_sum), e[63:0]);
        chk("b_cout", 64'(bb.out_cout), 64'(e[64]));
        chk("b_ovf", 64'(bb.out_ovf), 64'(e[65]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one beat, waits (bounded) for acceptance, records expectations.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub);
    int n;
    n = 0;
    vld_d = 1'b1; a_d = a; b_d = b; cin_d = cin; sub_d = sub;
    @(negedge clk);
    while (!ba.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", 64'(ba.in_ready), 64'd1);
    q_a.push_back(model(64'(a), 64'(b), cin, sub, 16, 1'b0));
    q_b.push_back(model(64'(a), 64'(b), cin, sub, 16, 1'b1));
    tick();
  endtask

  task automatic latency_check(input string tag);
    chk({tag, "_e0"}, 64'(ba.out_valid), 64'd0);
    tick();
    chk({tag, "_e1"}, 64'(ba.out_valid), 64'd0);
    tick();
    chk({tag, "_e2"}, 64'(ba.out_valid), 64'd1);
  endtask

  for (genvar k = 0; k < 16; k++) begin : g_cfg
    localparam int W  = (k % 4 == 0) ? 5 : (k % 4 == 1) ? 16 : (k % 4 == 2) ? 32 : 64;
    localparam int MR = (k / 4) % 2;
    localparam int S  = k / 8;
    logic [65:0] q[$];

    lf_pipe_adder_if #(.WIDTH(W)) bi();
    lf_pipe_adder #(.WIDTH(W), .MID_REG(MR), .SAT(S)) u_dut (.clk(clk), .rst(rst_r), .bus(bi));

    initial begin
      int sent, n;
      sent = 0;
      bi.in_valid = 1'b0; bi.in_a = '0; bi.in_b = '0;
      bi.in_cin = 1'b0; bi.in_sub = 1'b0; bi.out_ready = 1'b0;
      wait (rand_go);
      while (sent < NB) begin
        tick();
        bi.in_valid  = ($urandom_range(0, 3) != 0);
        bi.in_a      = W'({$urandom, $urandom});
        bi.in_b      = W'({$urandom, $urandom});
        bi.in_cin    = 1'($urandom_range(0, 1));
        bi.in_sub    = 1'($urandom_range(0, 1));
        bi.out_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (bi.in_valid && bi.in_ready) begin
          q.push_back(model(64'(bi.in_a), 64'(bi.in_b), bi.in_cin, bi.in_sub, W, S != 0));
          sent++;
        end
      end
      tick();
      bi.in_valid = 1'b0;
      bi.out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 50) begin
        tick();
        n++;
      end
      chk($sformatf("rnd%0d_drain", k), 64'(q.size()), 64'd0);
      ndone++;
    end

    always @(negedge clk) begin
      logic [65:0] e;
      if (!rst_r && bi.out_valid && bi.out_ready) begin
        if (q.size() == 0) chk($sformatf("rnd%0d_extra", k), 64'(bi.out_sum), 64'hDEAD);
        else begin
          e = q.pop_front();
          chk($sformatf("rnd%0d_sum", k), 64'(bi.out_sum), e[63:0]);
          chk($sformatf("rnd%0d_cout", k), 64'(bi.out_cout), 64'(e[64]));
          chk($sformatf("rnd%0d_ovf", k), 64'(bi.out_ovf), 64'(e[65]));
        end
      end
    end
  end

  initial begin
    int n;
    vld_d = 1'b0; a_d = '0; b_d = '0; cin_d = 1'b0; sub_d = 1'b0; ordy_d = 1'b1;
    rst_d = 1'b1; rst_r = 1'b1; rand_go = 1'b0;
    #12;
    chk("rst_out_valid", 64'(ba.out_valid), 64'd0);
    chk("rst_out_sum", 64'(ba.out_sum), 64'd0);
    chk("rst_out_cout", 64'(ba.out_cout), 64'd0);
    chk("rst_out_ovf", 64'(ba.out_ovf), 64'd0);
    tick();
    rst_d = 1'b0;
    rst_r = 1'b0;
    chk("rst_in_ready", 64'(ba.in_ready), 64'd1);
    rand_go = 1'b1;

    send(16'h1234, 16'h4321, 1'b0, 1'b0);
    vld_d = 1'b0;
    latency_check("lat");
    repeat (3) tick();

    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1);
    send(16'h00FF, 16'h0F00, 1'b1, 1'b0);
    send(16'h0010, 16'h0003, 1'b1, 1'b1);
    vld_d = 1'b0;
    repeat (6) tick();

    fork
      begin
        for (int i = 0; i < 6; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        vld_d = 1'b0;
      end
      begin
        int m;
        m = 0;
        do begin
          @(posedge clk);
          #2;
          m++;
        end while (!ba.out_valid && m < 30);
        chk("bp_seen_valid", 64'(ba.out_valid), 64'd1);
        ordy_d = 1'b0;
        snap_s = ba.out_sum;
        snap_a = u_a.a_p0;
        repeat (4) begin
          @(negedge clk);
          chk("bp_in_ready", 64'(ba.in_ready), 64'd0);
          chk("bp_out_valid", 64'(ba.out_valid), 64'd1);
          chk("bp_sum_stable", 64'(ba.out_sum), 64'(snap_s));
          chk("bp_a_p0_stable", 64'(u_a.a_p0), 64'(snap_a));
          @(posedge clk);
          #2;
        end
        ordy_d = 1'b1;
      end
    join
    n = 0;
    while (q_a.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    chk("bp_drain", 64'(q_a.size()), 64'd0);
    repeat (2) tick();

    send(16'h0101, 16'h0202, 1'b0, 1'b0);
    send(16'h0303, 16'h0404, 1'b0, 1'b0);
    vld_d = 1'b0;
    tick();
    chk("mid_rst_valid_before", 64'(ba.out_valid), 64'd1);
    #1 rst_d = 1'b1;
    #1;
    chk("mid_rst_valid_async", 64'(ba.out_valid), 64'd0);
    chk("mid_rst_sum_async", 64'(ba.out_sum), 64'd0);
    q_a.delete();
    q_b.delete();
    repeat (2) tick();
    rst_d = 1'b0;
    repeat (5) begin
      tick();
      chk("post_rst_no_stale", 64'(ba.out_valid), 64'd0);
    end
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    vld_d = 1'b0;
    latency_check("post_rst_lat");
    chk("post_rst_sum", 64'(ba.out_sum), 64'h0002);
    repeat (4) tick();
    chk("post_rst_drain", 64'(q_a.size()), 64'd0);

    n = 0;
    while (ndone < 16 && n < 80000) begin
      tick();
      n++;
    end
    chk("rnd_all_done", 64'(ndone), 64'd16);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
